wrr_packet_arbiter: RTL and testbench

//  Parametrised weighted round-robin arbiter with packet-boundary grant locking, for the crossbar output stage.

---
 rtl/wrr_packet_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_wrr_packet_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wrr_packet_arbiter
// Description : Weighted round-robin arbiter with packet-boundary grant
//               locking for the crossbar output stage. A requester may send
//               up to its weight in whole packets back-to-back before
//               priority rotates past it. The grant is combinational from
//               request_i; lock, owner, pointer and credit are registered.
//
// Ports       : clk_i          clock, rising edge
//               rst_i          synchronous active-high reset
//               request_i      per-requester request (level)
//               last_i         per-requester end-of-packet, valid with request
//               weight_i       packed weights, field i = [i*P_WEIGHT_W +: P_WEIGHT_W]
//               grant_o        one-hot grant or all-zero
//               grant_idx_o    index of the granted requester, 0 when none
//               grant_valid_o  |grant_o
//               timeout_o      one-cycle pulse after a forced release
//
// Options     : ARB_HOLD_TIMEOUT_EN - when defined, a packet holding the
//               grant for P_MAX_HOLD cycles without last_i is released and
//               the pointer moves past its owner.
//
// Revision    : 1.0 - initial release
// ============================================================================
module wrr_packet_arbiter #(
  parameter int P_WIDTH    = 4,
  parameter int P_WEIGHT_W = 4,
  parameter int P_MAX_HOLD = 64,
  localparam int C_IDX_W   = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [P_WIDTH-1:0]            request_i,
  input  logic [P_WIDTH-1:0]            last_i,
  input  logic [P_WIDTH*P_WEIGHT_W-1:0] weight_i,
  output logic [P_WIDTH-1:0]            grant_o,
  output logic [C_IDX_W-1:0]            grant_idx_o,
  output logic                          grant_valid_o,
  output logic                          timeout_o
);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic                  r_lock;
  logic [C_IDX_W-1:0]    r_owner;
  logic [C_IDX_W-1:0]    r_ptr;
  logic [P_WEIGHT_W-1:0] r_credit;

  // --------------------------------------------------------------------------
  // Combinational arbitration
  // --------------------------------------------------------------------------
  logic                  w_hold_owner;
  logic                  w_abort;
  logic [C_IDX_W-1:0]    w_base;
  logic [P_WEIGHT_W-1:0] w_base_credit;
  logic                  w_search_found;
  logic [C_IDX_W-1:0]    w_search_idx;
  logic                  w_grant_valid;
  logic [C_IDX_W-1:0]    w_grant_idx;
  logic                  w_last;
  logic [P_WEIGHT_W-1:0] w_cnt_credit;
  logic [P_WEIGHT_W-1:0] w_weight_raw;
  logic [P_WEIGHT_W-1:0] w_weight_eff;
  logic [P_WEIGHT_W:0]   w_credit_inc;
  logic                  w_exhaust;
  logic                  w_trigger;

  function automatic logic [C_IDX_W-1:0] f_inc(input logic [C_IDX_W-1:0] v);
    if (int'(v) >= P_WIDTH - 1) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  assign w_hold_owner = r_lock & request_i[r_owner];
  assign w_abort      = r_lock & ~request_i[r_owner];

  // On an abort the search restarts just past the old owner in the same
  // cycle, so the output never idles while someone else is waiting.
  assign w_base        = w_abort ? f_inc(r_owner) : r_ptr;
  assign w_base_credit = w_abort ? '0 : r_credit;

  always_comb begin
    w_search_found = 1'b0;
    w_search_idx   = '0;
    for (int k = 0; k < P_WIDTH; k++) begin
      if (!w_search_found && request_i[(int'(w_base) + k) % P_WIDTH]) begin
        w_search_found = 1'b1;
        w_search_idx   = C_IDX_W'((int'(w_base) + k) % P_WIDTH);
      end
    end
  end

  assign w_grant_valid = w_hold_owner | w_search_found;
  assign w_grant_idx   = w_hold_owner ? r_owner : w_search_idx;
  assign w_last        = w_grant_valid & last_i[w_grant_idx];

  // Credit counted for this packet: a continuing owner keeps its count, a
  // fresh winner that is not the priority holder starts from zero.
  always_comb begin
    w_cnt_credit = '0;
    if (w_hold_owner) begin
      w_cnt_credit = r_credit;
    end else if (w_search_idx == w_base) begin
      w_cnt_credit = w_base_credit;
    end
  end

  assign w_weight_raw = weight_i[int'(w_grant_idx)*P_WEIGHT_W +: P_WEIGHT_W];
  assign w_weight_eff = (w_weight_raw == '0) ? {{(P_WEIGHT_W-1){1'b0}}, 1'b1} : w_weight_raw;
  assign w_credit_inc = {1'b0, w_cnt_credit} + {{P_WEIGHT_W{1'b0}}, 1'b1};
  assign w_exhaust    = (w_credit_inc >= {1'b0, w_weight_eff});

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int C_HOLD_W = (P_MAX_HOLD > 1) ? $clog2(P_MAX_HOLD + 1) : 1;

  logic [C_HOLD_W-1:0] r_hold_cnt;
  logic [C_HOLD_W-1:0] w_hold_base;
  logic                r_timeout;

  // The stored count belongs to the current owner only; any fresh grant
  // (including one issued in an abort cycle) starts counting at zero.
  assign w_hold_base = w_hold_owner ? r_hold_cnt : '0;
  assign w_trigger   = w_grant_valid & ~w_last &
                       (w_hold_base == C_HOLD_W'(P_MAX_HOLD - 1));
  assign timeout_o   = r_timeout;
`else
  logic w_unused_max_hold;

  assign w_unused_max_hold = (P_MAX_HOLD == 0);
  assign w_trigger         = 1'b0;
  assign timeout_o         = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock   <= 1'b0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_credit <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
      r_timeout <= w_trigger;
`endif
      if (w_grant_valid) begin
        if (w_last || w_trigger) begin
          // Packet complete (or forcibly released): drop the lock and
          // either keep priority or rotate past the winner.
          r_lock <= 1'b0;
          if (w_exhaust || w_trigger) begin
            r_credit <= '0;
            r_ptr    <= f_inc(w_grant_idx);
          end else begin
            r_credit <= w_credit_inc[P_WEIGHT_W-1:0];
            r_ptr    <= w_grant_idx;
          end
`ifdef ARB_HOLD_TIMEOUT_EN
          r_hold_cnt <= '0;
`endif
        end else begin
          // Multi-cycle packet in progress.
          r_lock   <= 1'b1;
          r_owner  <= w_grant_idx;
          r_credit <= w_cnt_credit;
          r_ptr    <= w_base;
`ifdef ARB_HOLD_TIMEOUT_EN
          r_hold_cnt <= w_hold_base + 1'b1;
`endif
        end
      end else if (w_abort) begin
        // Owner dropped and nobody else is requesting.
        r_lock   <= 1'b0;
        r_credit <= '0;
        r_ptr    <= f_inc(r_owner);
`ifdef ARB_HOLD_TIMEOUT_EN
        r_hold_cnt <= '0;
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < P_WIDTH; gi++) begin : g_grant
    assign grant_o[gi] = w_grant_valid && (w_grant_idx == C_IDX_W'(gi));
  end

  assign grant_idx_o   = w_grant_valid ? w_grant_idx : '0;
  assign grant_valid_o = w_grant_valid;

endmodule
`default_nettype wire

// File: tb/tb_wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrr_packet_arbiter
// Description : Self-checking bench for wrr_packet_arbiter. Directed
//               scenarios followed by randomized traffic, every cycle
//               compared against a behavioural packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_packet_arbiter;

  localparam int C_N        = 4;
  localparam int C_WW       = 4;
  localparam int C_MAX_HOLD = 8;

  logic            clk;
  logic            rst;
  logic [C_N-1:0]  request;
  logic [C_N-1:0]  last_in;
  logic [15:0]     weights;
  logic [C_N-1:0]  grant;
  logic [1:0]      grant_idx;
  logic            grant_valid;
  logic            timeout;

  int n_tests;
  int n_fail;

  // model state: packet-level view of the arbiter
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_served;
  int m_pkt_cycles;
  bit m_timeout;
  bit e_valid;
  int e_idx;

  // last observed outputs
  int obs_grant;
  int obs_idx;
  int obs_tmo;

  wrr_packet_arbiter #(
    .P_WIDTH    (C_N),
    .P_WEIGHT_W (C_WW),
    .P_MAX_HOLD (C_MAX_HOLD)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .request_i     (request),
    .last_i        (last_in),
    .weight_i      (weights),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .timeout_o     (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked     = 0;
    m_owner      = 0;
    m_ptr        = 0;
    m_served     = 0;
    m_pkt_cycles = 0;
    m_timeout    = 0;
  endtask

  // Who should be granted now, given the current inputs.
  task automatic model_eval();
    int start;
    e_valid = 0;
    e_idx   = 0;
    if (m_locked && request[m_owner]) begin
      e_valid = 1;
      e_idx   = m_owner;
    end else begin
      start = m_locked ? (m_owner + 1) % C_N : m_ptr;
      for (int k = 0; k < C_N; k++) begin
        if (!e_valid && request[(start + k) % C_N]) begin
          e_valid = 1;
          e_idx   = (start + k) % C_N;
        end
      end
    end
  endtask

  // Advance the model by one clock using the grant from model_eval.
  task automatic model_update();
    bit cont;
    bit tmo;
    int w;
    cont = m_locked && request[m_owner];
    if (m_locked && !cont) begin
      m_ptr        = (m_owner + 1) % C_N;
      m_served     = 0;
      m_locked     = 0;
      m_pkt_cycles = 0;
    end
    m_timeout = 0;
    if (e_valid) begin
      if (!cont) begin
        if (e_idx != m_ptr) m_served = 0;
        m_ptr        = e_idx;
        m_pkt_cycles = 0;
      end
`ifdef ARB_HOLD_TIMEOUT_EN
      tmo = !last_in[e_idx] && (m_pkt_cycles == C_MAX_HOLD - 1);
`else
      tmo = 0;
`endif
      if (last_in[e_idx] || tmo) begin
        m_served = m_served + 1;
        w = int'(weights[e_idx*C_WW +: C_WW]);
        if (w == 0) w = 1;
        if (m_served >= w || tmo) begin
          m_ptr    = (e_idx + 1) % C_N;
          m_served = 0;
        end
        m_locked     = 0;
        m_pkt_cycles = 0;
        m_timeout    = tmo;
      end else begin
        m_locked     = 1;
        m_owner      = e_idx;
        m_pkt_cycles = m_pkt_cycles + 1;
      end
    end
  endtask

  // One clock: drive, compare at the falling edge, then advance the model.
  task automatic cycle(input logic [C_N-1:0] req, input logic [C_N-1:0] lst);
    request = req;
    last_in = lst;
    #4;
    model_eval();
    obs_grant = int'(grant);
    obs_idx   = int'(grant_idx);
    obs_tmo   = int'(timeout);
    check("grant",   32'(grant),       e_valid ? (32'd1 << e_idx) : 32'd0);
    check("idx",     32'(grant_idx),   e_valid ? 32'(e_idx) : 32'd0);
    check("valid",   32'(grant_valid), 32'(e_valid));
    check("timeout", 32'(timeout),     32'(m_timeout));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset(input logic [C_N-1:0] req);
    rst     = 1'b1;
    request = req;
    last_in = '0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    request = '0;
    last_in = '0;
    weights = 16'h1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    cycle(4'b0000, 4'b0000);
    check("rst_grant", 32'(obs_grant), 0);
    check("rst_idx",   32'(obs_idx),   0);
    check("rst_tmo",   32'(obs_tmo),   0);

    // 1: single-cycle packets rotate 0,1,2,3,...
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 4'b1111);
      check("t1_idx", 32'(obs_idx), 32'(i % 4));
    end

    // 2: 5-cycle packet from req0 blocks req1
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0011, (i == 4) ? 4'b0001 : 4'b0000);
      check("t2_lock", 32'(obs_grant), 1);
    end
    cycle(4'b0010, 4'b0010);
    check("t2_next", 32'(obs_grant), 2);

    // 3: weight0=3, 2-cycle packets from req0/req1 -> 0,0,0,1,0,0,0,1
    weights = 16'h1113;
    for (int p = 0; p < 8; p++) begin
      cycle(4'b0011, 4'b0000);
      check("t3_order", 32'(obs_idx), (p % 4 == 3) ? 1 : 0);
      cycle(4'b0011, 4'b0011);
    end
    weights = 16'h1111;

    // 4: req2 locked then drops; req3 takes over without a bubble
    cycle(4'b0100, 4'b0000);
    check("t4_lock", 32'(obs_grant), 4);
    cycle(4'b1001, 4'b1000);
    check("t4_abort", 32'(obs_grant), 8);
    cycle(4'b1001, 4'b1001);
    check("t4_after", 32'(obs_idx), 0);

    // 5: reset while req1 is locked mid-packet
    cycle(4'b0010, 4'b0000);
    check("t5_lock", 32'(obs_grant), 2);
    do_reset(4'b0011);
    cycle(4'b0011, 4'b0011);
    check("t5_post", 32'(obs_idx), 0);

    // 6: req0 never ends its packet while req1 waits
    cycle(4'b0001, 4'b0000);
    for (int c = 2; c <= 12; c++) begin
      cycle(4'b0011, 4'b0000);
`ifdef ARB_HOLD_TIMEOUT_EN
      if (c <= C_MAX_HOLD) check("t6_hold", 32'(obs_grant), 1);
      if (c == C_MAX_HOLD + 1) begin
        check("t6_tgrant", 32'(obs_grant), 2);
        check("t6_tpulse", 32'(obs_tmo),   1);
      end
`else
      check("t6_hold", 32'(obs_grant), 1);
      check("t6_tmo",  32'(obs_tmo),   0);
`endif
    end
    cycle(4'b0000, 4'b0000);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) weights = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset(4'($urandom));
      end else begin
        cycle(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
